// File: rtl/unidade_controle_mc.sv
// Multi-cycle control FSM for the nRISC core: fetch, decode, execute, memory
// and write-back sequencing with a memory-ready handshake.
module unidade_controle_mc #(
  parameter int LARG_OP = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [LARG_OP-1:0] opcode,
  input  logic               mem_pronta,
  output logic               ir_escreve,
  output logic               pc_escreve,
  output logic               pc_escreve_cond,
  output logic [1:0]         pc_fonte,
  output logic               reg_escreve,
  output logic [1:0]         reg_fonte,
  output logic [1:0]         sinalt2,
  output logic [2:0]         ula_op,
  output logic               ula_fonte_b,
  output logic               mem_le,
  output logic               mem_escreve,
  output logic               ilegal,
  output logic               parado,
  output logic [2:0]         estado
);

  typedef enum logic [2:0] {
    BUSCA  = 3'b000,
    DECOD  = 3'b001,
    EXEC   = 3'b010,
    MEM    = 3'b011,
    ESCR   = 3'b100,
    PARADO = 3'b101
  } estado_t;

  localparam logic [LARG_OP-1:0] OP_LI   = 4'b0101;
  localparam logic [LARG_OP-1:0] OP_LW   = 4'b0110;
  localparam logic [LARG_OP-1:0] OP_SW   = 4'b0111;
  localparam logic [LARG_OP-1:0] OP_BEQ  = 4'b1000;
  localparam logic [LARG_OP-1:0] OP_JAL  = 4'b1001;
  localparam logic [LARG_OP-1:0] OP_JR   = 4'b1010;
  localparam logic [LARG_OP-1:0] OP_HALT = 4'b1111;
  localparam logic [LARG_OP-1:0] OP_SLT  = 4'b0100;

  estado_t estado_q, estado_d;
  logic    op_r;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) estado_q <= BUSCA;
    else          estado_q <= estado_d;
  end

  assign op_r   = (opcode <= OP_SLT);
  assign estado = estado_q;

  // Outputs are gated by reset_n so nothing is requested while reset is held,
  // even though the state register already reads BUSCA.
  always_comb begin
    estado_d        = estado_q;
    ir_escreve      = 1'b0;
    pc_escreve      = 1'b0;
    pc_escreve_cond = 1'b0;
    pc_fonte        = 2'b00;
    reg_escreve     = 1'b0;
    reg_fonte       = 2'b00;
    sinalt2         = 2'b00;
    ula_op          = 3'b000;
    ula_fonte_b     = 1'b0;
    mem_le          = 1'b0;
    mem_escreve     = 1'b0;
    ilegal          = 1'b0;
    parado          = 1'b0;
    if (reset_n) begin
      unique case (estado_q)
        BUSCA: begin
          mem_le     = 1'b1;
          ir_escreve = mem_pronta;
          pc_escreve = mem_pronta;
          if (mem_pronta) estado_d = DECOD;
        end
        DECOD: begin
          if (op_r || opcode == OP_LW || opcode == OP_SW ||
              opcode == OP_BEQ || opcode == OP_JR)
            estado_d = EXEC;
          else if (opcode == OP_LI || opcode == OP_JAL)
            estado_d = ESCR;
          else if (opcode == OP_HALT)
            estado_d = PARADO;
          else begin
            ilegal   = 1'b1;
            estado_d = BUSCA;
          end
        end
        EXEC: begin
          estado_d = BUSCA;
          if (op_r) begin
            ula_op   = opcode[2:0];
            estado_d = ESCR;
          end else if (opcode == OP_LW || opcode == OP_SW) begin
            ula_fonte_b = 1'b1;
            estado_d    = MEM;
          end else if (opcode == OP_BEQ) begin
            ula_op          = 3'b001;
            pc_escreve_cond = 1'b1;
            pc_fonte        = 2'b01;
          end else if (opcode == OP_JR) begin
            pc_escreve = 1'b1;
            pc_fonte   = 2'b11;
          end
        end
        MEM: begin
          if (opcode == OP_LW) begin
            mem_le = 1'b1;
            if (mem_pronta) estado_d = ESCR;
          end else if (opcode == OP_SW) begin
            mem_escreve = 1'b1;
            if (mem_pronta) estado_d = BUSCA;
          end else begin
            estado_d = BUSCA;
          end
        end
        ESCR: begin
          estado_d    = BUSCA;
          reg_escreve = 1'b1;
          if (opcode == OP_LW) begin
            reg_fonte = 2'b01;
          end else if (opcode == OP_LI) begin
            reg_fonte = 2'b10;
            sinalt2   = 2'b01;
          end else if (opcode == OP_JAL) begin
            reg_fonte  = 2'b11;
            sinalt2    = 2'b10;
            pc_escreve = 1'b1;
            pc_fonte   = 2'b10;
          end
        end
        PARADO: begin
          parado = 1'b1;
        end
        default: estado_d = BUSCA;
      endcase
    end
  end

endmodule

// File: tb/tb_unidade_controle_mc.sv
// Directed bench for unidade_controle_mc: walks each instruction class
// cycle by cycle and compares the full output bundle against hand values.
module tb_unidade_controle_mc;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] opcode = 4'b0000;
  logic       mem_pronta = 1'b0;
  logic       ir_escreve, pc_escreve, pc_escreve_cond, reg_escreve;
  logic [1:0] pc_fonte, reg_fonte, sinalt2;
  logic [2:0] ula_op, estado;
  logic       ula_fonte_b, mem_le, mem_escreve, ilegal, parado;

  typedef struct packed {
    logic       ir_e;
    logic       pc_e;
    logic       pc_ec;
    logic [1:0] pc_f;
    logic       reg_e;
    logic [1:0] reg_f;
    logic [1:0] t2;
    logic [2:0] ula;
    logic       ufb;
    logic       mle;
    logic       mes;
    logic       ileg;
    logic       par;
    logic [2:0] est;
  } outs_t;

  outs_t obs, e;
  int unsigned passed = 0;
  int unsigned total  = 0;

  always #5 clock = ~clock;

  unidade_controle_mc #(.LARG_OP(4)) dut (
    .clock(clock), .reset_n(reset_n), .opcode(opcode), .mem_pronta(mem_pronta),
    .ir_escreve(ir_escreve), .pc_escreve(pc_escreve), .pc_escreve_cond(pc_escreve_cond),
    .pc_fonte(pc_fonte), .reg_escreve(reg_escreve), .reg_fonte(reg_fonte),
    .sinalt2(sinalt2), .ula_op(ula_op), .ula_fonte_b(ula_fonte_b), .mem_le(mem_le),
    .mem_escreve(mem_escreve), .ilegal(ilegal), .parado(parado), .estado(estado)
  );

  always_comb obs = {ir_escreve, pc_escreve, pc_escreve_cond, pc_fonte, reg_escreve,
                     reg_fonte, sinalt2, ula_op, ula_fonte_b, mem_le, mem_escreve,
                     ilegal, parado, estado};

  function automatic outs_t z(input logic [2:0] est);
    outs_t r;
    r = '0;
    r.est = est;
    return r;
  endfunction

  task automatic chk(input string tag, input outs_t exp_v);
    total++;
    assert (obs === exp_v) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
  endtask

  // New cycle: inputs change mid-cycle, sampled 1 ns later, far from posedge.
  task automatic cyc(input logic [3:0] op, input logic mp);
    @(negedge clock);
    opcode     = op;
    mem_pronta = mp;
    #1;
  endtask

  initial begin
    // reset held
    #2;
    e = z(3'b000); chk("reset_hold", e);
    @(negedge clock); @(negedge clock);
    opcode = 4'b0001; mem_pronta = 1'b1; reset_n = 1'b1; #1;

    // SUB
    e = z(3'b000); e.ir_e = 1; e.pc_e = 1; e.mle = 1; chk("sub_busca", e);
    cyc(4'b0001, 1'b1); e = z(3'b001); chk("sub_decod", e);
    cyc(4'b0001, 1'b1); e = z(3'b010); e.ula = 3'b001; chk("sub_exec", e);
    cyc(4'b0001, 1'b1); e = z(3'b100); e.reg_e = 1; chk("sub_escr", e);

    // LI
    cyc(4'b0101, 1'b1); e = z(3'b000); e.ir_e = 1; e.pc_e = 1; e.mle = 1; chk("li_busca", e);
    cyc(4'b0101, 1'b1); e = z(3'b001); chk("li_decod", e);
    cyc(4'b0101, 1'b1); e = z(3'b100); e.reg_e = 1; e.reg_f = 2'b10; e.t2 = 2'b01; chk("li_escr", e);

    // JAL
    cyc(4'b1001, 1'b1); e = z(3'b000); e.ir_e = 1; e.pc_e = 1; e.mle = 1; chk("jal_busca", e);
    cyc(4'b1001, 1'b1); e = z(3'b001); chk("jal_decod", e);
    cyc(4'b1001, 1'b1); e = z(3'b100); e.reg_e = 1; e.reg_f = 2'b11; e.t2 = 2'b10;
    e.pc_e = 1; e.pc_f = 2'b10; chk("jal_escr", e);

    // LW with 3 wait cycles in fetch and 2 in memory: 10 cycles
    for (int i = 0; i < 3; i++) begin
      cyc(4'b0110, 1'b0); e = z(3'b000); e.mle = 1; chk("lw_busca_wait", e);
    end
    cyc(4'b0110, 1'b1); e = z(3'b000); e.ir_e = 1; e.pc_e = 1; e.mle = 1; chk("lw_busca", e);
    cyc(4'b0110, 1'b0); e = z(3'b001); chk("lw_decod", e);
    cyc(4'b0110, 1'b0); e = z(3'b010); e.ufb = 1; chk("lw_exec", e);
    for (int i = 0; i < 2; i++) begin
      cyc(4'b0110, 1'b0); e = z(3'b011); e.mle = 1; chk("lw_mem_wait", e);
    end
    cyc(4'b0110, 1'b1); e = z(3'b011); e.mle = 1; chk("lw_mem", e);
    cyc(4'b0110, 1'b0); e = z(3'b100); e.reg_e = 1; e.reg_f = 2'b01; chk("lw_escr", e);

    // BEQ
    cyc(4'b1000, 1'b1); e = z(3'b000); e.ir_e = 1; e.pc_e = 1; e.mle = 1; chk("beq_busca", e);
    cyc(4'b1000, 1'b1); e = z(3'b001); chk("beq_decod", e);
    cyc(4'b1000, 1'b1); e = z(3'b010); e.ula = 3'b001; e.pc_ec = 1; e.pc_f = 2'b01; chk("beq_exec", e);

    // JR
    cyc(4'b1010, 1'b1); e = z(3'b000); e.ir_e = 1; e.pc_e = 1; e.mle = 1; chk("jr_busca", e);
    cyc(4'b1010, 1'b1); e = z(3'b001); chk("jr_decod", e);
    cyc(4'b1010, 1'b1); e = z(3'b010); e.pc_e = 1; e.pc_f = 2'b11; chk("jr_exec", e);

    // SLT
    cyc(4'b0100, 1'b1); e = z(3'b000); e.ir_e = 1; e.pc_e = 1; e.mle = 1; chk("slt_busca", e);
    cyc(4'b0100, 1'b1); e = z(3'b001); chk("slt_decod", e);
    cyc(4'b0100, 1'b1); e = z(3'b010); e.ula = 3'b100; chk("slt_exec", e);
    cyc(4'b0100, 1'b1); e = z(3'b100); e.reg_e = 1; chk("slt_escr", e);

    // SW, no wait
    cyc(4'b0111, 1'b1); e = z(3'b000); e.ir_e = 1; e.pc_e = 1; e.mle = 1; chk("sw_busca", e);
    cyc(4'b0111, 1'b1); e = z(3'b001); chk("sw_decod", e);
    cyc(4'b0111, 1'b1); e = z(3'b010); e.ufb = 1; chk("sw_exec", e);
    cyc(4'b0111, 1'b1); e = z(3'b011); e.mes = 1; chk("sw_mem", e);

    // Illegal 1100
    cyc(4'b1100, 1'b1); e = z(3'b000); e.ir_e = 1; e.pc_e = 1; e.mle = 1; chk("ileg_busca", e);
    cyc(4'b1100, 1'b1); e = z(3'b001); e.ileg = 1; chk("ileg_decod", e);
    cyc(4'b1100, 1'b0); e = z(3'b000); e.mle = 1; chk("ileg_back", e);
    cyc(4'b1100, 1'b0); e = z(3'b000); e.mle = 1; chk("ileg_stay", e);

    // HALT
    cyc(4'b1111, 1'b1); e = z(3'b000); e.ir_e = 1; e.pc_e = 1; e.mle = 1; chk("halt_busca", e);
    cyc(4'b1111, 1'b1); e = z(3'b001); chk("halt_decod", e);
    for (int i = 0; i < 22; i++) begin
      cyc(4'(i), 1'(i)); e = z(3'b101); e.par = 1; chk("parado", e);
    end
    @(negedge clock); reset_n = 1'b0; #1;
    e = z(3'b000); chk("halt_reset", e);
    @(negedge clock); opcode = 4'b0111; mem_pronta = 1'b1; reset_n = 1'b1; #1;

    // SW with memory waiting, reset dropped mid-MEM together with mem_pronta
    e = z(3'b000); e.ir_e = 1; e.pc_e = 1; e.mle = 1; chk("sw2_busca", e);
    cyc(4'b0111, 1'b1); e = z(3'b001); chk("sw2_decod", e);
    cyc(4'b0111, 1'b1); e = z(3'b010); e.ufb = 1; chk("sw2_exec", e);
    cyc(4'b0111, 1'b0); e = z(3'b011); e.mes = 1; chk("sw2_mem_wait", e);
    #1; reset_n = 1'b0; mem_pronta = 1'b1; #1;
    e = z(3'b000); chk("sw2_async_reset", e);
    @(posedge clock); #1;
    e = z(3'b000); chk("sw2_reset_edge", e);
    @(negedge clock); mem_pronta = 1'b0; reset_n = 1'b1; #1;
    e = z(3'b000); e.mle = 1; chk("release_busca", e);
    cyc(4'b0111, 1'b1); e = z(3'b000); e.ir_e = 1; e.pc_e = 1; e.mle = 1; chk("release_fetch", e);
    cyc(4'b0111, 1'b1); e = z(3'b001); chk("release_decod", e);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
